// File: rtl/vga_pkg.sv
// Shared 1280x1024@60Hz timing constants, colour width and small helpers for the VGA path.
package vga_pkg;

  localparam int unsigned COLOR_W = 8;
  localparam int unsigned CNT_W   = 11;

  localparam int unsigned VGA_H_ACTIVE = 1280;
  localparam int unsigned VGA_H_FP     = 48;
  localparam int unsigned VGA_H_SYNC   = 112;
  localparam int unsigned VGA_H_BP     = 248;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 1024;
  localparam int unsigned VGA_V_FP     = 1;
  localparam int unsigned VGA_V_SYNC   = 3;
  localparam int unsigned VGA_V_BP     = 38;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Control bits that must stay aligned with the pixel generator's colour
  typedef struct packed {
    logic en;
    logic hs;
    logic vs;
  } ctl_t;

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-generator and DAC-side signals of the VGA timing block.
interface vga_timing_if;
  import vga_pkg::*;

  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               disp_en;
  logic               frame_start;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic               VGA_SYNC_N;

  modport master (
    output x, y, disp_en, frame_start,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input  r, g, b
  );

  modport slave (
    input  x, y, disp_en, frame_start,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output r, g, b
  );

endinterface

// File: rtl/vga_delay.sv
// Generic N-stage shift register with synchronous active-low clear.
module vga_delay #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator and pixel sink: scans h/v counters, realigns sync/blank to the
// registered colour from the pixel generator and drives the DAC pins.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        H_POL    = 1'b1,
  parameter logic        V_POL    = 1'b1,
  parameter int unsigned PIX_LAT  = 1
) (
  input logic          VGA_CLK,
  input logic          VGA_RST_N,
  vga_timing_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  ctl_t             ctl_raw;
  ctl_t             ctl_d;

  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    ctl_raw    = '0;
    ctl_raw.en = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    ctl_raw.hs = in_window(h_cnt, HS_LO, HS_HI);
    ctl_raw.vs = in_window(v_cnt, VS_LO, VS_HI);
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.disp_en     = ctl_raw.en;
  // Gated by reset so the held-at-zero counters do not look like a frame start
  assign bus.frame_start = VGA_RST_N && (h_cnt == '0) && (v_cnt == '0);
  assign bus.VGA_SYNC_N  = 1'b0;

  vga_delay #(
    .W ($bits(ctl_t)),
    .N (PIX_LAT)
  ) u_align (
    .clk   (VGA_CLK),
    .rst_n (VGA_RST_N),
    .d     (ctl_raw),
    .q     (ctl_d)
  );

  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      bus.VGA_R       <= '0;
      bus.VGA_G       <= '0;
      bus.VGA_B       <= '0;
      bus.VGA_BLANK_N <= 1'b0;
      bus.VGA_HS      <= ~H_POL;
      bus.VGA_VS      <= ~V_POL;
    end else begin
      bus.VGA_R       <= ctl_d.en ? bus.r : '0;
      bus.VGA_G       <= ctl_d.en ? bus.g : '0;
      bus.VGA_B       <= ctl_d.en ? bus.b : '0;
      bus.VGA_BLANK_N <= ctl_d.en;
      bus.VGA_HS      <= ctl_d.hs ^ ~H_POL;
      bus.VGA_VS      <= ctl_d.vs ^ ~V_POL;
    end
  end

endmodule
